// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V writeback stage: result select, load align/extend, MEM wait FSM
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage #(
  parameter  int WIDTH      = 32,
  parameter  int REG_ADDR_W = 5,
  localparam int OFF_W      = $clog2(WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [OFF_W-1:0]      in_addr_lo,
  input  logic [WIDTH-1:0]      in_alu_data,
  input  logic [WIDTH-1:0]      in_pc4,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  mem_rvalid,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]      rf_wdata,
  output logic                  wb_valid,
  output logic [63:0]           retire_count
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

  localparam logic [1:0]       SEL_ALU = 2'b00;
  localparam logic [1:0]       SEL_MEM = 2'b01;
  localparam logic [1:0]       SEL_PC4 = 2'b10;
  localparam logic [WIDTH-1:0] ALL1    = '1;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_wb_valid;
  logic                    r_rf_we;
  logic [REG_ADDR_W-1:0]   r_waddr;
  logic [WIDTH-1:0]        r_wdata;

  logic [REG_ADDR_W-1:0]   r_ld_rd;
  logic [2:0]              r_ld_f3;
  logic [OFF_W-1:0]        r_ld_off;
  logic                    r_ld_we;

  logic [WIDTH-1:0]        w_sel_data;
  logic [WIDTH-1:0]        w_shifted;
  logic [WIDTH-1:0]        w_mask;
  logic                    w_sign;
  logic                    w_sext;
  logic [WIDTH-1:0]        w_aligned;

  always_comb begin
    w_sel_data = in_imm;
    case (in_wb_sel)
      SEL_ALU: w_sel_data = in_alu_data;
      SEL_PC4: w_sel_data = in_pc4;
      default: w_sel_data = in_imm;
    endcase
  end

  // Misaligned offsets simply shift whatever bytes are there down to bit 0.
  assign w_shifted = mem_rdata >> {r_ld_off, 3'b000};

  always_comb begin
    w_mask = ALL1;
    w_sign = 1'b0;
    w_sext = ~r_ld_f3[2];
    case (r_ld_f3)
      3'b000, 3'b100: begin
        w_mask = ALL1 >> (WIDTH - 8);
        w_sign = w_shifted[7];
      end
      3'b001, 3'b101: begin
        w_mask = ALL1 >> (WIDTH - 16);
        w_sign = w_shifted[15];
      end
      3'b010, 3'b110: begin
        w_mask = ALL1 >> (WIDTH - 32);
        w_sign = w_shifted[31];
      end
      default: begin
        w_mask = ALL1;
        w_sign = 1'b0;
        w_sext = 1'b0;
      end
    endcase
  end

  assign w_aligned = (w_shifted & w_mask) | ((w_sext && w_sign) ? ~w_mask : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_wb_valid <= 1'b0;
      r_rf_we    <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_ld_rd    <= '0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
      r_ld_we    <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_rf_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_wb_sel == SEL_MEM) begin
              r_ld_rd  <= in_rd;
              r_ld_f3  <= in_funct3;
              r_ld_off <= in_addr_lo;
              r_ld_we  <= in_reg_write;
              r_ready  <= 1'b0;
              r_state  <= ST_WAIT_MEM;
            end else begin
              r_wb_valid <= 1'b1;
              r_rf_we    <= in_reg_write && (in_rd != '0);
              r_waddr    <= in_rd;
              r_wdata    <= w_sel_data;
            end
          end
        end
        ST_WAIT_MEM: begin
          // in_valid is deliberately ignored here; MEM holds it until in_ready returns.
          if (mem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_rf_we    <= r_ld_we && (r_ld_rd != '0);
            r_waddr    <= r_ld_rd;
            r_wdata    <= w_aligned;
            r_ready    <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign wb_valid = r_wb_valid;
  assign rf_we    = r_rf_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] r_retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire <= '0;
    end else if (r_wb_valid) begin
      r_retire <= r_retire + 64'd1;
    end
  end

  assign retire_count = r_retire;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized scoreboard bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_data, in_pc4, in_imm;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [63:0] retire_count;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_data(in_alu_data),
    .in_pc4(in_pc4), .in_imm(in_imm), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_valid(wb_valid),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t    q[$];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  longint  model_ret = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Byte/half extraction by plain arithmetic on the shifted word.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return s;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    longint exp_ret;
    if (rst) begin
      model_ret = 0;
    end else if (wb_valid) begin
`ifdef WB_RETIRE_COUNT_EN
      exp_ret = model_ret;
`else
      exp_ret = 0;
`endif
      if (q.size() == 0) begin
        check("unexpected_wb_valid", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("wb_cycle", 64'(cyc), 64'(e.cyc));
        check("rf_we", 64'(rf_we), 64'(e.we));
        check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        check("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
      check("retire_count", retire_count, 64'(exp_ret));
      model_ret++;
    end else begin
      check("rf_we_without_valid", 64'(rf_we), 64'd0);
    end
  end

  task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                      input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [31:0] rdata, input int k);
    exp_t e;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_wb_sel = sel; in_rd = rd; in_reg_write = rw;
    in_funct3 = f3; in_addr_lo = off; in_alu_data = alu; in_pc4 = pc4; in_imm = imm;
    if (sel != 2'b01 && $urandom_range(0, 1) == 1) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rvalid = 1'b0; in_rd = 5'($urandom); in_wb_sel = 2'($urandom);
    e.addr = rd;
    e.we = rw && (rd != 5'd0);
    if (sel != 2'b01) begin
      e.cyc = cyc;
      e.data = (sel == 2'b00) ? alu : (sel == 2'b10) ? pc4 : imm;
      q.push_back(e);
    end else begin
      for (int i = 1; i < k; i++) begin
        check("in_ready_wait", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
      check("in_ready_wait", 64'(in_ready), 64'd0);
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      e.cyc = cyc;
      e.data = ld_model(f3, int'(off), rdata);
      q.push_back(e);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_data = '0; in_pc4 = '0; in_imm = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset_retire", retire_count, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(2'b00, 5'd5, 1'b1, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 1);
    send(2'b01, 5'd3, 1'b1, 3'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h80FF_0000, 3);
    send(2'b01, 5'd4, 1'b1, 3'd4, 2'd3, 32'h0, 32'h0, 32'h0, 32'h80FF_0000, 3);
    send(2'b01, 5'd6, 1'b1, 3'd1, 2'd2, 32'h0, 32'h0, 32'h0, 32'h8001_0000, 1);
    send(2'b01, 5'd8, 1'b1, 3'd5, 2'd2, 32'h0, 32'h0, 32'h0, 32'h8001_0000, 2);
    send(2'b00, 5'd0, 1'b1, 3'd0, 2'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0, 1);
    send(2'b00, 5'd7, 1'b0, 3'd0, 2'd0, 32'hBEEF, 32'h0, 32'h0, 32'h0, 1);
    send(2'b10, 5'd10, 1'b1, 3'd0, 2'd0, 32'h0, 32'h104, 32'h55, 32'h0, 1);
    send(2'b11, 5'd11, 1'b1, 3'd0, 2'd0, 32'h0, 32'h108, 32'h66, 32'h0, 1);
    send(2'b10, 5'd12, 1'b1, 3'd0, 2'd0, 32'h0, 32'h10C, 32'h77, 32'h0, 1);
    send(2'b11, 5'd13, 1'b1, 3'd0, 2'd0, 32'h0, 32'h110, 32'h88, 32'h0, 1);
    repeat (2) @(posedge clk); #1;

    // Reset while a load is outstanding: the load must vanish.
    in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd9; in_reg_write = 1'b1;
    in_funct3 = 3'd2; in_addr_lo = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_load_pending", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_mid_rf_we", 64'(rf_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    for (int n = 0; n < 120; n++) begin
      logic [1:0] sel;
      logic [2:0] f3;
      sel = 2'($urandom);
      f3 = 3'($urandom);
      send(sel, 5'($urandom), 1'($urandom), f3, 2'($urandom), $urandom, $urandom,
           $urandom, $urandom, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk); #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Pipelined RISC-V writeback stage: registers the MEM/WB boundary, selects among ALU, load, PC+4 and immediate results, and aligns and sign/zero-extends load data. Multi-cycle memory responses are absorbed by a small wait state machine with a valid/ready handshake back to MEM. Sits between the MEM stage and the register-file write port. Its registered output also feeds the forwarding unit.

## Interface
Parameters:
- WIDTH, 32, datapath width; legal values are 32 and 64.
- REG_ADDR_W, 5, register index width.
- OFF_W is a localparam equal to $clog2(WIDTH/8). It is the byte-offset width: 2 when WIDTH=32, 3 when WIDTH=64.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  instruction writes rd
- in_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
- in_funct3  in  3  load size/sign
- in_addr_lo  in  OFF_W  load byte offset
- in_alu_data, in_pc4, in_imm  in  WIDTH each  candidate results
- mem_rvalid  in  1  load data valid
- mem_rdata  in  WIDTH  raw memory word
- rf_we  out  1  register-file write strobe
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  WIDTH  write data
- wb_valid  out  1  an instruction completes this cycle
- retire_count  out  64  retired-instruction count

## Operation
- Reset value of every output is 0, except in_ready, which is 1 because the state resets to IDLE. Accepts are ignored while rst is high.
- States:
  - IDLE: accepts instructions; in_ready=1.
  - WAIT_MEM: waits for load data; in_ready=0.
- Accept means in_valid && in_ready at a rising edge.
- Non-load accept (wb_sel != 01) in IDLE:
  - The selected result is registered, and wb_valid=1 in the next cycle.
  - The FSM stays in IDLE, so throughput is one instruction per cycle.
- Load accept (wb_sel = 01): rd, funct3, addr_lo and reg_write are captured, and the FSM moves to WAIT_MEM.
- In WAIT_MEM, the cycle mem_rvalid=1 is seen:
  - The aligned data is registered and the FSM returns to IDLE.
  - wb_valid=1 in the following cycle.
- mem_rvalid is ignored in IDLE.
- Alignment: the word is shifted right by 8*addr_lo bits, then extended according to funct3:
  - 000 LB: sign-extend bits [7:0].
  - 100 LBU: zero-extend bits [7:0].
  - 001 LH: sign-extend bits [15:0].
  - 101 LHU: zero-extend bits [15:0].
  - 010 LW: sign-extend bits [31:0] (full word when WIDTH=32).
  - 110 LWU: zero-extend bits [31:0].
  - 011 LD: full WIDTH.
  - Any undefined funct3 is treated as full WIDTH.
- Misaligned offsets are not trapped; the shifted bytes are used as-is.
- Write gating:
  - rf_we = wb_valid && reg_write && (rd != 0).
  - rf_waddr and rf_wdata are valid whenever wb_valid=1.
  - Writes to x0 are suppressed, but the instruction still retires.
- When wb_valid=0, rf_we=0. rf_waddr and rf_wdata hold their last values.

## Timing
- Non-load latency is 1 cycle: accept at edge N gives wb_valid/rf_we during cycle N+1.
- Load latency is 1 cycle after mem_rvalid: with accept at N and mem_rvalid sampled at N+k (k≥1), wb_valid is high during N+k+1.
- in_ready drops the cycle after a load accept. It rises again the cycle after mem_rvalid is sampled, so back-to-back with a non-load is allowed at that edge.
- If mem_rvalid and in_valid are both high in WAIT_MEM, only the load completes; in_valid must be held by MEM.
- Asserting rst mid-load discards the load: the FSM returns to IDLE, wb_valid and rf_we go to 0 immediately, and no write occurs.
- wb_valid is a single-cycle pulse per retired instruction.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - A 64-bit counter increments on every cycle wb_valid=1, including non-writing and x0 instructions.
  - It resets to 0 and wraps from 2^64-1 to 0.
- Undefined: retire_count is tied to 0 and no counter flops are synthesised.

## Test plan
- ALU path: accept wb_sel=00, rd=5, alu=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234, wb_valid=1.
- Load LB, WIDTH=32: addr_lo=3, mem_rdata=0x80FF_0000 delivered 3 cycles after accept → in_ready=0 for those cycles, then rf_wdata=0xFFFFFF80; with LBU the result is 0x00000080.
- Load LH/LHU: addr_lo=2, mem_rdata=0x8001_0000 → LH gives 0xFFFF8001, LHU gives 0x00008001.
- x0 and no-write: rd=0 with reg_write=1, then rd=7 with reg_write=0 → wb_valid=1 both cycles, rf_we=0 both; with WB_RETIRE_COUNT_EN, retire_count advances by 2.
- Reset mid-load: assert rst while in WAIT_MEM → in_ready=1, wb_valid=0, and no rf_we ever occurs for that load even if mem_rvalid arrives after reset.
- Throughput: 4 consecutive PC+4/IMM instructions → 4 consecutive wb_valid pulses, with rf_wdata equal to in_pc4 or in_imm respectively.
